// File: rtl/traffic_defs_pkg.sv
// Shared definitions for the traffic light controller and its lamp safety monitor:
// FSM states, fault codes and the one-hot {red, yellow, green} lamp aspect encoding.
package traffic_defs;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE         = 2'b00,
    FC_CONFLICT     = 2'b01,
    FC_ILLEGAL      = 2'b10,
    FC_SHORT_YELLOW = 2'b11
  } fault_code_t;

  typedef enum logic [2:0] {
    ASPECT_DARK   = 3'b000,
    ASPECT_GREEN  = 3'b001,
    ASPECT_YELLOW = 3'b010,
    ASPECT_RED    = 3'b100
  } aspect_t;

  // True when more than one lamp of a {red, yellow, green} head is requested.
  function automatic logic multi_lamp(input logic [2:0] aspect);
    return (aspect[0] & aspect[1]) | (aspect[0] & aspect[2]) | (aspect[1] & aspect[2]);
  endfunction

endpackage

// File: rtl/traffic_head_checker.sv
// Per-head rule checker: tracks dark run length and yellow dwell, and flags
// illegal aspects and red entered too early after green/yellow.
module traffic_head_checker
  import traffic_defs::*;
#(
  parameter int unsigned MIN_YELLOW = 4,
  parameter int unsigned BLANK_MAX  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] req,
  input  logic       prev_green,
  input  logic       run,
  output logic       illegal,
  output logic       short_yellow
);

  localparam int unsigned DW = $clog2(BLANK_MAX + 2);
  localparam int unsigned YW = $clog2(MIN_YELLOW + 2);
  localparam logic [DW-1:0] DARK_SAT = DW'(BLANK_MAX + 1);
  localparam logic [YW-1:0] YEL_SAT  = YW'(MIN_YELLOW + 1);

  logic [DW-1:0] r_dark_cnt;
  logic [YW-1:0] r_yel_cnt;
  logic          r_yellow_valid;
  logic          w_dark;
  logic          w_yellow;
  logic          w_red;

  assign w_dark   = (req == ASPECT_DARK);
  assign w_yellow = req[1];
  assign w_red    = req[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dark_cnt     <= '0;
      r_yel_cnt      <= '0;
      r_yellow_valid <= 1'b0;
    end else begin
      if (!w_dark)
        r_dark_cnt <= '0;
      else if (r_dark_cnt != DARK_SAT)
        r_dark_cnt <= r_dark_cnt + 1'b1;

      if (!w_yellow)
        r_yel_cnt <= '0;
      else if (r_yel_cnt != YEL_SAT)
        r_yel_cnt <= r_yel_cnt + 1'b1;

      // A yellow phase is only judged if its first cycle was observed in RUN.
      if (!w_yellow)
        r_yellow_valid <= 1'b0;
      else if (r_yel_cnt == '0)
        r_yellow_valid <= run;
    end
  end

  assign illegal = multi_lamp(req) | (w_dark & (r_dark_cnt >= DW'(BLANK_MAX)));

  assign short_yellow = w_red & (prev_green |
                        (r_yellow_valid & (r_yel_cnt != '0) & (r_yel_cnt < YW'(MIN_YELLOW))));

endmodule

// File: rtl/traffic_lamp_safety_monitor.sv
// Lamp safety monitor: registers legal aspects through to the lamps and latches a
// fault with flashing red on any conflicting, illegal or short-yellow request.
module traffic_lamp_safety_monitor
  import traffic_defs::*;
#(
  parameter int unsigned MIN_YELLOW  = 4,
  parameter int unsigned BLANK_MAX   = 2,
  parameter int unsigned STARTUP_CYC = 8,
  parameter int unsigned FLASH_HALF  = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_red_a,
  input  logic       req_yellow_a,
  input  logic       req_green_a,
  input  logic       req_red_b,
  input  logic       req_yellow_b,
  input  logic       req_green_b,
  input  logic       fault_clr,
  output logic       red_a,
  output logic       yellow_a,
  output logic       green_a,
  output logic       red_b,
  output logic       yellow_b,
  output logic       green_b,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int unsigned SW = $clog2(STARTUP_CYC + 2);
  localparam int unsigned FW = $clog2(FLASH_HALF + 2);

  state_t        r_state;
  logic [SW-1:0] r_startup_cnt;
  logic [FW-1:0] r_flash_cnt;
  logic          r_phase;
  logic          r_prev_green_a;
  logic          r_prev_green_b;

  logic [2:0]    w_req_a;
  logic [2:0]    w_req_b;
  logic          w_run;
  logic          w_illegal_a;
  logic          w_illegal_b;
  logic          w_short_a;
  logic          w_short_b;
  logic          w_conflict;
  fault_code_t   w_code;

  assign w_req_a    = {req_red_a, req_yellow_a, req_green_a};
  assign w_req_b    = {req_red_b, req_yellow_b, req_green_b};
  assign w_run      = (r_state == ST_RUN);
  assign w_conflict = (req_green_a | req_yellow_a) & (req_green_b | req_yellow_b);

  traffic_head_checker #(
    .MIN_YELLOW(MIN_YELLOW),
    .BLANK_MAX (BLANK_MAX)
  ) u_head_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (w_req_a),
    .prev_green  (r_prev_green_a),
    .run         (w_run),
    .illegal     (w_illegal_a),
    .short_yellow(w_short_a)
  );

  traffic_head_checker #(
    .MIN_YELLOW(MIN_YELLOW),
    .BLANK_MAX (BLANK_MAX)
  ) u_head_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (w_req_b),
    .prev_green  (r_prev_green_b),
    .run         (w_run),
    .illegal     (w_illegal_b),
    .short_yellow(w_short_b)
  );

  always_comb begin
    w_code = FC_NONE;
    if (w_conflict)
      w_code = FC_CONFLICT;
    else if (w_illegal_a | w_illegal_b)
      w_code = FC_ILLEGAL;
    else if (w_short_a | w_short_b)
      w_code = FC_SHORT_YELLOW;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state                      <= ST_STARTUP;
      r_startup_cnt                <= '0;
      r_flash_cnt                  <= '0;
      r_phase                      <= 1'b1;
      r_prev_green_a               <= 1'b0;
      r_prev_green_b               <= 1'b0;
      {red_a, yellow_a, green_a}   <= ASPECT_RED;
      {red_b, yellow_b, green_b}   <= ASPECT_RED;
      fault                        <= 1'b0;
      fault_code                   <= FC_NONE;
    end else begin
      r_prev_green_a <= req_green_a;
      r_prev_green_b <= req_green_b;
      case (r_state)
        ST_STARTUP: begin
          {red_a, yellow_a, green_a} <= ASPECT_RED;
          {red_b, yellow_b, green_b} <= ASPECT_RED;
          fault                      <= 1'b0;
          if (r_startup_cnt == SW'(STARTUP_CYC - 1)) begin
            r_state       <= ST_RUN;
            r_startup_cnt <= '0;
          end else begin
            r_startup_cnt <= r_startup_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // The violating aspect is replaced by solid red on the same edge.
          if (w_code != FC_NONE) begin
            r_state                    <= ST_FAULT;
            r_phase                    <= 1'b1;
            r_flash_cnt                <= '0;
            fault                      <= 1'b1;
            fault_code                 <= w_code;
            {red_a, yellow_a, green_a} <= ASPECT_RED;
            {red_b, yellow_b, green_b} <= ASPECT_RED;
          end else begin
            {red_a, yellow_a, green_a} <= w_req_a;
            {red_b, yellow_b, green_b} <= w_req_b;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            r_state                    <= ST_STARTUP;
            r_startup_cnt              <= '0;
            fault                      <= 1'b0;
            fault_code                 <= FC_NONE;
            {red_a, yellow_a, green_a} <= ASPECT_RED;
            {red_b, yellow_b, green_b} <= ASPECT_RED;
          end else begin
            {yellow_a, green_a, yellow_b, green_b} <= '0;
            if (r_flash_cnt == FW'(FLASH_HALF - 1)) begin
              r_flash_cnt <= '0;
              r_phase     <= ~r_phase;
              red_a       <= ~r_phase;
              red_b       <= ~r_phase;
            end else begin
              r_flash_cnt <= r_flash_cnt + 1'b1;
              red_a       <= r_phase;
              red_b       <= r_phase;
            end
          end
        end
        default: r_state <= ST_STARTUP;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_lamp_safety_monitor.sv
// Scoreboard bench for the lamp safety monitor: directed scenarios followed by
// randomized traffic, checked against a history-based reference model.
module tb_traffic_lamp_safety_monitor;

  localparam int MIN_YELLOW  = 4;
  localparam int BLANK_MAX   = 2;
  localparam int STARTUP_CYC = 8;
  localparam int FLASH_HALF  = 16;

  localparam logic [2:0] D = 3'b000;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [8:0] RESET_VEC = 9'b100_100_0_00;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic req_red_a = 1'b1, req_yellow_a = 1'b0, req_green_a = 1'b0;
  logic req_red_b = 1'b1, req_yellow_b = 1'b0, req_green_b = 1'b0;
  logic fault_clr = 1'b0;
  logic red_a, yellow_a, green_a, red_b, yellow_b, green_b, fault;
  logic [1:0] fault_code;
  logic [8:0] w_out;

  always #5 clk = ~clk;

  traffic_lamp_safety_monitor #(
    .MIN_YELLOW (MIN_YELLOW),
    .BLANK_MAX  (BLANK_MAX),
    .STARTUP_CYC(STARTUP_CYC),
    .FLASH_HALF (FLASH_HALF)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_red_a   (req_red_a),
    .req_yellow_a(req_yellow_a),
    .req_green_a (req_green_a),
    .req_red_b   (req_red_b),
    .req_yellow_b(req_yellow_b),
    .req_green_b (req_green_b),
    .fault_clr   (fault_clr),
    .red_a       (red_a),
    .yellow_a    (yellow_a),
    .green_a     (green_a),
    .red_b       (red_b),
    .yellow_b    (yellow_b),
    .green_b     (green_b),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  assign w_out = {red_a, yellow_a, green_a, red_b, yellow_b, green_b, fault, fault_code};

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];

  // Reference model: mode 0 startup, 1 run, 2 fault; per-head request history since reset.
  int         m_state, m_scnt, m_fcnt;
  logic       m_phase;
  logic [1:0] m_code;
  logic [2:0] hist_a[$];
  logic [2:0] hist_b[$];
  bit         mode_h[$];

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] hat(input int h, input int i);
    return (h == 0) ? hist_a[i] : hist_b[i];
  endfunction

  // 0 ok, 2 illegal, 3 short yellow for one head given its history before this cycle.
  function automatic int head_check(input int h, input logic [2:0] cur);
    int n, len;
    logic [2:0] v;
    len = (h == 0) ? hist_a.size() : hist_b.size();
    if ($countones(cur) > 1) return 2;
    if (cur == D) begin
      n = 0;
      while (n < len && hat(h, len - 1 - n) == D) n++;
      if (n >= BLANK_MAX) return 2;
    end
    if (cur[2] && len > 0) begin
      v = hat(h, len - 1);
      if (v[0]) return 3;
      n = 0;
      v = hat(h, len - 1);
      while (n < len && v[1]) begin
        n++;
        if (n < len) v = hat(h, len - 1 - n);
      end
      if (n > 0 && n < MIN_YELLOW && mode_h[len - n]) return 3;
    end
    return 0;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_scnt = 0; m_fcnt = 0; m_phase = 1'b1; m_code = 2'b00;
    hist_a.delete(); hist_b.delete(); mode_h.delete();
  endfunction

  function automatic logic [8:0] model_step(input logic [2:0] a, input logic [2:0] b, input logic clr);
    logic [8:0] e;
    int code, ha, hb;
    code = 0;
    ha = head_check(0, a);
    hb = head_check(1, b);
    if ((a[1] | a[0]) && (b[1] | b[0])) code = 1;
    else if (ha == 2 || hb == 2) code = 2;
    else if (ha == 3 || hb == 3) code = 3;
    hist_a.push_back(a); hist_b.push_back(b); mode_h.push_back(m_state == 1);
    while (hist_a.size() > 16) begin
      void'(hist_a.pop_front()); void'(hist_b.pop_front()); void'(mode_h.pop_front());
    end
    e = RESET_VEC;
    case (m_state)
      0: begin
        if (m_scnt == STARTUP_CYC - 1) begin m_state = 1; m_scnt = 0; end
        else m_scnt++;
      end
      1: begin
        if (code != 0) begin
          m_state = 2; m_code = 2'(code); m_phase = 1'b1; m_fcnt = 0;
          e = {R, R, 1'b1, m_code};
        end else begin
          e = {a, b, 3'b000};
        end
      end
      default: begin
        if (clr) begin
          m_state = 0; m_scnt = 0; m_code = 2'b00;
        end else begin
          if (m_fcnt == FLASH_HALF - 1) begin m_fcnt = 0; m_phase = ~m_phase; end
          else m_fcnt++;
          e = {m_phase, 2'b00, m_phase, 2'b00, 1'b1, m_code};
        end
      end
    endcase
    return e;
  endfunction

  // Called at a falling edge; applies one cycle of requests and queues the expected result.
  task automatic cycle(input logic [2:0] a, input logic [2:0] b, input logic clr);
    logic [8:0] e;
    {req_red_a, req_yellow_a, req_green_a} = a;
    {req_red_b, req_yellow_b, req_green_b} = b;
    fault_clr = clr;
    e = model_step(a, b, clr);
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 check("reset_state", w_out, RESET_VEC);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic clear_and_start();
    cycle(R, R, 1'b1);
    repeat (STARTUP_CYC + 1) cycle(R, R, 1'b0);
  endtask

  task automatic drive(input int act, input logic [2:0] asp);
    logic [2:0] a, b;
    logic clr;
    a = (act == 0) ? asp : R;
    b = (act == 0) ? R : asp;
    if ($urandom_range(0, 19) == 0) a = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 19) == 0) b = 3'($urandom_range(0, 7));
    clr = (m_state == 2 && $urandom_range(0, 7) == 0) || ($urandom_range(0, 49) == 0);
    cycle(a, b, clr);
  endtask

  always begin
    logic [8:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", w_out, e);
    end
  end

  initial begin
    model_reset();
    #3 reset_n = 1'b0;
    #1 check("reset_state", w_out, RESET_VEC);
    @(negedge clk);
    reset_n = 1'b1;

    cycle(D, D, 1'b0);
    repeat (STARTUP_CYC + 3) cycle(R, G, 1'b0);

    cycle(G, G, 1'b0);
    repeat (40) cycle(R, R, 1'b0);
    clear_and_start();

    repeat (2) cycle(G, R, 1'b0);
    repeat (3) cycle(Y, R, 1'b0);
    cycle(R, R, 1'b0);
    clear_and_start();
    repeat (2) cycle(G, R, 1'b0);
    repeat (4) cycle(Y, R, 1'b0);
    repeat (2) cycle(R, R, 1'b0);
    cycle(G, R, 1'b0);
    cycle(R, R, 1'b0);
    clear_and_start();

    repeat (3) cycle(D, R, 1'b0);
    cycle(R, R, 1'b0);
    clear_and_start();
    repeat (2) cycle(D, R, 1'b0);
    cycle(R, R, 1'b0);
    cycle(3'b101, R, 1'b0);
    clear_and_start();

    cycle(3'b011, G, 1'b0);
    repeat (3) cycle(R, R, 1'b0);
    clear_and_start();
    repeat (3) cycle(R, G, 1'b0);

    cycle(G, G, 1'b0);
    for (int i = 0; i < 3 * FLASH_HALF && !(m_state == 2 && m_phase == 1'b0); i++)
      cycle(R, R, 1'b0);
    check("flash_off_before_reset", w_out, 9'b000_000_1_01);
    do_reset();

    for (int k = 0; k < 120; k++) begin
      int act, gl, yl, rl;
      act = $urandom_range(0, 1);
      gl  = $urandom_range(1, 5);
      yl  = $urandom_range(2, 6);
      rl  = $urandom_range(1, 3);
      for (int i = 0; i < gl; i++) drive(act, G);
      for (int i = 0; i < yl; i++) drive(act, Y);
      for (int i = 0; i < rl; i++) drive(act, R);
      if (k == 60) do_reset();
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 9'(exp_q.size()), 9'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
